iter_multiplier: RTL and testbench
==================================

ITER_MULTIPLIER -- requirements
Module: iter_multiplier

Interface
REQ-001 Parameter: WIDTH, 32, operand width in bits; product width is 2*WIDTH.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 MultStart  input  1  multiply request from the execute-stage instruction; level, held by the pipeline while stalled.
REQ-005 MultSigned  input  1  1 = signed (two's complement) operands, 0 = unsigned.
REQ-006 Flush  input  1  abort any operation in progress.
REQ-007 SrcA  input  WIDTH  multiplicand.
REQ-008 SrcB  input  WIDTH  multiplier.
REQ-009 ProdV  output  1  product-valid pulse; consumed by the hazard unit to release StallE.
REQ-010 Prod  output  2*WIDTH  product {hi, lo}, registered.
REQ-011 Busy  output  1  high while in RUN.

Function
REQ-012 The block SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-013 IDLE: if MultStart=1 and Flush=0, latch operands, clear accumulator, load iteration counter with WIDTH, go to RUN; otherwise stay.
REQ-014 RUN: each cycle, if multiplier LSB=1 add multiplicand to accumulator upper half; shift {carry, accumulator} right one bit; decrement counter.
REQ-015 RUN: when counter reaches 1 on the current step, go to DONE on the next edge (exactly WIDTH cycles in RUN).
REQ-016 DONE: ProdV SHALL be 1 for exactly one cycle, Prod SHALL hold the final product; next state is IDLE regardless of MultStart.
REQ-017 Latency: MultStart sampled in IDLE at edge N -> ProdV=1 during cycle N+WIDTH+1.
REQ-018 MultStart SHALL be ignored in RUN and DONE; a held-high MultStart during RUN SHALL NOT restart the operation.
REQ-019 Back-to-back: MultStart high in the IDLE cycle following DONE SHALL start a new operation with that cycle's operands.
REQ-020 Flush=1 in any state SHALL force IDLE on the next edge, suppress ProdV, and leave Prod unchanged; Flush has priority over MultStart.
REQ-021 Prod SHALL update only on entry to DONE and hold its value until the next DONE.
REQ-022 Accumulator addition SHALL be WIDTH+1 bits wide so no carry is lost; product is exact modulo 2^(2*WIDTH).
REQ-023 Busy SHALL equal (state==RUN); ProdV SHALL equal (state==DONE).

Reset
REQ-024 reset_n=0 SHALL asynchronously force IDLE, ProdV=0, Busy=0, Prod=0, counter=0, accumulator=0.
REQ-025 Reset asserted mid-RUN SHALL discard the operation; no ProdV after reset release until a new MultStart.
REQ-026 Reset release SHALL be synchronous-safe: first state change no earlier than the first rising edge with reset_n=1.

Configuration
REQ-027 Macro MULT_SIGNED_EN: when defined, MultSigned=1 SHALL convert operands to magnitudes at start and negate the product at DONE if operand signs differ; latency unchanged.
REQ-028 When MULT_SIGNED_EN is undefined, MultSigned SHALL be ignored and all operands treated as unsigned; port remains present.

Verification
REQ-029 Unsigned: SrcA=0x0000_FFFF, SrcB=0x0001_0001, MultStart in IDLE -> ProdV at cycle 33, Prod=0x0000_0000_FFFF_FFFF.
REQ-030 Max operands: SrcA=SrcB=0xFFFF_FFFF, MultSigned=0 -> Prod=0xFFFF_FFFE_0000_0001.
REQ-031 Signed (MULT_SIGNED_EN): SrcA=0xFFFF_FFFD (-3), SrcB=7, MultSigned=1 -> Prod=0xFFFF_FFFF_FFFF_FFEB (-21); without macro -> Prod=0x0000_0006_FFFF_FFEB.
REQ-032 MultStart held high through RUN and DONE -> exactly one ProdV pulse, then a second operation starts in the following IDLE cycle, second ProdV 33 cycles later.
REQ-033 Flush at RUN cycle 10 -> IDLE next cycle, no ProdV, Prod retains previous result.
REQ-034 reset_n low at RUN cycle 5 -> outputs zero immediately, no ProdV after release until new MultStart.

Source files
------------

// File: rtl/iter_multiplier.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH cycles per product.
// Define MULT_SIGNED_EN to honour MultSigned (sign-magnitude around the unsigned core).
module iter_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 MultStart,
  input  logic                 MultSigned,
  input  logic                 Flush,
  input  logic [WIDTH-1:0]     SrcA,
  input  logic [WIDTH-1:0]     SrcB,
  output logic                 ProdV,
  output logic [2*WIDTH-1:0]   Prod,
  output logic                 Busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               stateReg, stateNext;
  logic [WIDTH-1:0]     mcandReg, mcandNext;
  logic [2*WIDTH-1:0]   accReg, accNext;
  logic [CW-1:0]        cntReg, cntNext;
  logic                 negReg, negNext;
  logic [2*WIDTH-1:0]   prodReg, prodNext;

  logic [WIDTH-1:0]     opA, opB;
  logic                 opNeg;
  logic [WIDTH:0]       partial;
  logic [2*WIDTH-1:0]   shifted;

`ifdef MULT_SIGNED_EN
  always_comb begin
    opNeg = MultSigned & (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
    opA   = (MultSigned && SrcA[WIDTH-1]) ? (~SrcA + WIDTH'(1)) : SrcA;
    opB   = (MultSigned && SrcB[WIDTH-1]) ? (~SrcB + WIDTH'(1)) : SrcB;
  end
`else
  logic unusedSigned;
  assign unusedSigned = MultSigned;
  always_comb begin
    opNeg = 1'b0;
    opA   = SrcA;
    opB   = SrcB;
  end
`endif

  // Upper half accumulates, lower half holds the multiplier bits still to be consumed.
  assign partial = {1'b0, accReg[2*WIDTH-1:WIDTH]}
                 + (accReg[0] ? {1'b0, mcandReg} : {(WIDTH+1){1'b0}});
  assign shifted = {partial, accReg[WIDTH-1:1]};

  always_comb begin
    stateNext = stateReg;
    mcandNext = mcandReg;
    accNext   = accReg;
    cntNext   = cntReg;
    negNext   = negReg;
    prodNext  = prodReg;
    if (Flush) begin
      stateNext = IDLE;
    end else begin
      case (stateReg)
        IDLE: begin
          if (MultStart) begin
            mcandNext = opA;
            accNext   = {{WIDTH{1'b0}}, opB};
            cntNext   = CW'(WIDTH);
            negNext   = opNeg;
            stateNext = RUN;
          end
        end
        RUN: begin
          accNext = shifted;
          cntNext = cntReg - CW'(1);
          if (cntReg == CW'(1)) begin
            stateNext = DONE;
            prodNext  = negReg ? (~shifted + (2*WIDTH)'(1)) : shifted;
          end
        end
        DONE:    stateNext = IDLE;
        default: stateNext = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stateReg <= IDLE;
      mcandReg <= '0;
      accReg   <= '0;
      cntReg   <= '0;
      negReg   <= 1'b0;
      prodReg  <= '0;
    end else begin
      stateReg <= stateNext;
      mcandReg <= mcandNext;
      accReg   <= accNext;
      cntReg   <= cntNext;
      negReg   <= negNext;
      prodReg  <= prodNext;
    end
  end

  assign Prod  = prodReg;
  assign ProdV = (stateReg == DONE);
  assign Busy  = (stateReg == RUN);

endmodule

// File: tb/tb_iter_multiplier.sv
// Directed bench for iter_multiplier: cycle-level transaction model plus literal expectations.
module tb_iter_multiplier;
  localparam int WIDTH = 32;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        MultStart = 1'b0;
  logic        MultSigned = 1'b0;
  logic        Flush = 1'b0;
  logic [31:0] SrcA = '0;
  logic [31:0] SrcB = '0;
  logic        ProdV;
  logic [63:0] Prod;
  logic        Busy;

  iter_multiplier #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset_n(reset_n), .MultStart(MultStart), .MultSigned(MultSigned),
    .Flush(Flush), .SrcA(SrcA), .SrcB(SrcB), .ProdV(ProdV), .Prod(Prod), .Busy(Busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int passCnt = 0;
  int checkCnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checkCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got 0x%h, expected 0x%h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [63:0] refProd(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
`ifdef MULT_SIGNED_EN
    if (s) return 64'(sa * sb);
`endif
    if (s && (sa == sb)) return {32'b0, a} * {32'b0, b};
    return {32'b0, a} * {32'b0, b};
  endfunction

  // Transaction model: an accepted request delivers a*b after WIDTH cycles of work.
  logic        mBusy, mValid;
  logic [63:0] mProd, mPend;
  int          mLeft;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mBusy <= 1'b0; mValid <= 1'b0; mProd <= '0; mPend <= '0; mLeft <= 0;
    end else if (Flush) begin
      mBusy <= 1'b0; mValid <= 1'b0;
    end else if (mValid) begin
      mValid <= 1'b0;
    end else if (mBusy) begin
      mLeft <= mLeft - 1;
      if (mLeft == 1) begin
        mBusy <= 1'b0; mValid <= 1'b1; mProd <= mPend;
      end
    end else if (MultStart) begin
      mBusy <= 1'b1; mLeft <= WIDTH; mPend <= refProd(SrcA, SrcB, MultSigned);
    end
  end

  always @(negedge clk) begin
    check("ProdV", 64'(ProdV), 64'(mValid));
    check("Busy", 64'(Busy), 64'(mBusy));
    check("Prod", Prod, mProd);
  end

  task automatic startOp(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(negedge clk);
    SrcA = a; SrcB = b; MultSigned = s; MultStart = 1'b1;
    @(negedge clk);
    MultStart = 1'b0;
  endtask

  task automatic runOp(input string name, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic [63:0] expProd);
    int startCyc, lat;
    bit found;
    startOp(a, b, s);
    startCyc = cyc;
    found = 0;
    lat = -1;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (ProdV) begin found = 1; lat = cyc - startCyc; end
    end
    check({name, "_latency"}, 64'(lat), 64'(WIDTH));
    check({name, "_prod"}, Prod, expProd);
    $display("op %s: 0x%h * 0x%h signed=%0d -> 0x%h after %0d cycles", name, a, b, s, Prod, lat);
  endtask

  initial begin
    int pulses, firstCyc, secondCyc, flushedV, resetV;
    logic [63:0] firstProd, secondProd, heldProd;

    repeat (3) @(negedge clk);
    #1;
    check("reset_Prod", Prod, 64'h0);
    check("reset_ProdV", 64'(ProdV), 64'h0);
    check("reset_Busy", 64'(Busy), 64'h0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_Busy", 64'(Busy), 64'h0);

    runOp("ffff_x_10001", 32'h0000_FFFF, 32'h0001_0001, 1'b0, 64'h0000_0000_FFFF_FFFF);
    runOp("max_unsigned", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
`ifdef MULT_SIGNED_EN
    runOp("neg3_x_7", 32'hFFFF_FFFD, 32'h0000_0007, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB);
    runOp("minint_x_2", 32'h8000_0000, 32'h0000_0002, 1'b1, 64'hFFFF_FFFF_0000_0000);
    runOp("neg1_x_neg1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001);
`else
    runOp("neg3_x_7", 32'hFFFF_FFFD, 32'h0000_0007, 1'b1, 64'h0000_0006_FFFF_FFEB);
    runOp("minint_x_2", 32'h8000_0000, 32'h0000_0002, 1'b1, 64'h0000_0001_0000_0000);
    runOp("neg1_x_neg1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFE_0000_0001);
`endif
    runOp("seven_x_six", 32'd7, 32'd6, 1'b0, 64'd42);
    runOp("zero_x_any", 32'd0, 32'h1234_5678, 1'b0, 64'd0);

    // Held request: operands changed after acceptance must not affect the first product.
    @(negedge clk);
    SrcA = 32'd3; SrcB = 32'd5; MultSigned = 1'b0; MultStart = 1'b1;
    @(negedge clk);
    SrcA = 32'd11; SrcB = 32'd13;
    pulses = 0; firstCyc = 0; secondCyc = 0; firstProd = '0; secondProd = '0;
    for (int i = 0; i < 100 && pulses < 2; i++) begin
      @(negedge clk);
      if (ProdV) begin
        pulses++;
        if (pulses == 1) begin firstCyc = cyc; firstProd = Prod; end
        else begin secondCyc = cyc; secondProd = Prod; MultStart = 1'b0; end
      end
    end
    MultStart = 1'b0;
    check("held_pulses", 64'(pulses), 64'd2);
    check("held_first_prod", firstProd, 64'd15);
    check("held_second_prod", secondProd, 64'd143);
    // DONE, one IDLE cycle that re-accepts, WIDTH RUN cycles, then DONE again.
    check("held_interval", 64'(secondCyc - firstCyc), 64'(WIDTH + 2));
    $display("op held: first=0x%h second=0x%h interval=%0d", firstProd, secondProd, secondCyc - firstCyc);

    // Flush in the tenth RUN cycle.
    heldProd = Prod;
    startOp(32'd9, 32'd9, 1'b0);
    repeat (9) @(negedge clk);
    Flush = 1'b1;
    @(negedge clk);
    Flush = 1'b0;
    check("flush_busy", 64'(Busy), 64'h0);
    flushedV = 0;
    repeat (40) begin @(negedge clk); if (ProdV) flushedV++; end
    check("flush_no_prodv", 64'(flushedV), 64'd0);
    check("flush_prod_kept", Prod, heldProd);
    $display("op flush: 9*9 aborted, Prod kept 0x%h", Prod);

    // Flush wins over a simultaneous request.
    @(negedge clk);
    SrcA = 32'd2; SrcB = 32'd2; MultStart = 1'b1; Flush = 1'b1;
    @(negedge clk);
    MultStart = 1'b0; Flush = 1'b0;
    check("flush_prio_busy", 64'(Busy), 64'h0);
    $display("op flush_priority: request with Flush not accepted");

    // Reset in the fifth RUN cycle.
    startOp(32'd5, 32'd5, 1'b0);
    repeat (4) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("midrun_reset_Prod", Prod, 64'h0);
    check("midrun_reset_Busy", 64'(Busy), 64'h0);
    check("midrun_reset_ProdV", 64'(ProdV), 64'h0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    resetV = 0;
    repeat (40) begin @(negedge clk); if (ProdV) resetV++; end
    check("reset_no_prodv", 64'(resetV), 64'd0);
    $display("op reset: 5*5 discarded, no ProdV after release");

    runOp("after_reset", 32'd6, 32'd7, 1'b0, 64'd42);

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end
endmodule
